// File: rtl/simon_tempo_ctrl_if.sv
// Control/status bundle between the Simon game FSM and the playback tempo sequencer.
interface simon_tempo_ctrl_if;
  logic       start;
  logic       abort;
  logic [4:0] count;
  logic [3:0] level;
  logic [4:0] step;
  logic       led_on;
  logic       busy;
  logic       done;
  logic       tick;

  // Game FSM side: issues requests, observes pacing.
  modport master (
    output start, abort, count, level,
    input  step, led_on, busy, done, tick
  );

  // Sequencer side.
  modport slave (
    input  start, abort, count, level,
    output step, led_on, busy, done, tick
  );
endinterface

// File: rtl/simon_tempo_ctrl.sv
// Simon playback tempo sequencer: prescaled base tick, per-step LED-on phase
// followed by a gap, with phase lengths that shrink with difficulty level.
module simon_tempo_ctrl #(
  parameter int unsigned TICK_DIV  = 100000,
  parameter int unsigned ON_BASE   = 400,
  parameter int unsigned OFF_BASE  = 200,
  parameter int unsigned ON_STEP   = 25,
  parameter int unsigned OFF_STEP  = 10,
  parameter int unsigned MIN_TICKS = 50
) (
  input  logic                 clkin,
  input  logic                 rst,
  simon_tempo_ctrl_if.slave    bus
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned TW = 16;
  localparam int unsigned SW = 5;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] ON_BASE_W  = TW'(ON_BASE);
  localparam logic [TW-1:0] OFF_BASE_W = TW'(OFF_BASE);
  localparam logic [TW-1:0] MIN_W      = TW'(MIN_TICKS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] on_ticks_q;
  logic [TW-1:0] off_ticks_q;
  logic [SW-1:0] count_q;
  logic [SW-1:0] step_q;
  logic          led_on_q;
  logic          busy_q;
  logic          done_q;
  logic          tick_q;

  logic [TW-1:0] on_red;
  logic [TW-1:0] off_red;
  logic [TW-1:0] on_ticks_d;
  logic [TW-1:0] off_ticks_d;
  logic          tick_evt;
  logic          timer_last;
  logic          last_step;

  // Level-scaled phase lengths, floored; compare first so a large level cannot wrap.
  always_comb begin
    on_red      = TW'(bus.level) * TW'(ON_STEP);
    off_red     = TW'(bus.level) * TW'(OFF_STEP);
    on_ticks_d  = MIN_W;
    off_ticks_d = MIN_W;
    if (ON_BASE_W > on_red) begin
      if ((ON_BASE_W - on_red) >= MIN_W) begin
        on_ticks_d = ON_BASE_W - on_red;
      end
    end
    if (OFF_BASE_W > off_red) begin
      if ((OFF_BASE_W - off_red) >= MIN_W) begin
        off_ticks_d = OFF_BASE_W - off_red;
      end
    end
  end

  // Base-tick event and phase-expiry qualifiers.
  always_comb begin
    tick_evt   = (presc_q == PRESC_LAST);
    timer_last = (timer_q == TW'(1));
    last_step  = (step_q == SW'(count_q - SW'(1)));
  end

  // Sequencer state, prescaler, phase timer and registered outputs.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      timer_q     <= '0;
      on_ticks_q  <= '0;
      off_ticks_q <= '0;
      count_q     <= '0;
      step_q      <= '0;
      led_on_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      // Free-running prescaler; transitions below restart it on a tick boundary.
      tick_q  <= tick_evt;
      presc_q <= tick_evt ? '0 : PW'(presc_q + PW'(1));
      done_q  <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            presc_q     <= '0;
            on_ticks_q  <= on_ticks_d;
            off_ticks_q <= off_ticks_d;
            count_q     <= bus.count;
            step_q      <= '0;
            busy_q      <= 1'b1;
            if (bus.count != '0) begin
              state_q  <= S_ON;
              led_on_q <= 1'b1;
              timer_q  <= on_ticks_d;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end

        S_ON: begin
          if (bus.abort) begin
            state_q  <= S_IDLE;
            led_on_q <= 1'b0;
            busy_q   <= 1'b0;
            step_q   <= '0;
          end else if (tick_evt) begin
            if (timer_last) begin
              presc_q  <= '0;
              led_on_q <= 1'b0;
              if (last_step) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_OFF;
                timer_q <= off_ticks_q;
              end
            end else begin
              timer_q <= TW'(timer_q - TW'(1));
            end
          end
        end

        S_OFF: begin
          if (bus.abort) begin
            state_q  <= S_IDLE;
            led_on_q <= 1'b0;
            busy_q   <= 1'b0;
            step_q   <= '0;
          end else if (tick_evt) begin
            if (timer_last) begin
              presc_q  <= '0;
              state_q  <= S_ON;
              led_on_q <= 1'b1;
              step_q   <= SW'(step_q + SW'(1));
              timer_q  <= on_ticks_q;
            end else begin
              timer_q <= TW'(timer_q - TW'(1));
            end
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (bus.abort) begin
            step_q <= '0;
          end
        end

        default: begin
          state_q  <= S_IDLE;
          led_on_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.step   = step_q;
  assign bus.led_on = led_on_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.tick   = tick_q;

endmodule
